// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the loadable program memory.
// Defines the FSM states, the default widths and the NOP instruction word.
package prog_mem_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      LOADING,
      RUN
   } prog_mem_state_t;

   localparam int DEFAULT_ADDR_W = 8;
   localparam int DEFAULT_DATA_W = 8;

   // Value returned for any fetch outside the loaded program, and outside RUN.
   localparam logic [DEFAULT_DATA_W-1:0] NOP = '0;

endpackage

// File: rtl/prog_mem_ram.sv
// Simple dual-port synchronous RAM.
// One write port and one read port with a registered output, shaped so that it maps onto block RAM.
module prog_mem_ram
   import prog_mem_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the array and its read register have no reset, so the tools can map them onto block RAM.
   // The top module's length gate keeps stale contents from ever being seen.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem.sv
// Loadable program memory with a valid/ready byte-stream load port and a gated 1-cycle fetch port.
// The FSM, the program length counter, the overflow flag and the fetch gating live here.
module prog_mem
   import prog_mem_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic              load_last,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              run_ready,
   output logic              load_overflow,
   output logic [ADDR_W:0]   prog_len
);

   prog_mem_state_t state_q, state_d;
   logic [ADDR_W:0] prog_len_q, prog_len_d;
   logic            overflow_q, overflow_d;
   logic            load_ready_q, load_ready_d;
   logic            run_ready_q, run_ready_d;
   logic            fetch_valid_q, fetch_valid_d;
   logic            sel_ram_q, sel_ram_d;

   logic            ram_we;
   logic            fetch_acc;
   logic            fetch_hit;
   logic [DATA_W-1:0] ram_rdata;

   // NOTE: every signal assigned below gets a default first, so no path through the block leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      prog_len_d = prog_len_q;
      overflow_d = overflow_q;
      ram_we     = 1'b0;

      if (load_start) begin
         // A restart wins over a word offered in the same cycle; that word is dropped.
         state_d    = LOADING;
         prog_len_d = '0;
         overflow_d = 1'b0;
      end else if (state_q == LOADING && load_valid) begin
         if (load_ready_q) begin
            ram_we     = 1'b1;
            prog_len_d = prog_len_q + (ADDR_W + 1)'(1);
            if (load_last) begin
               state_d = RUN;
            end
         end else begin
            // The image is already full: keep it, flag the overflow and start running.
            overflow_d = 1'b1;
            state_d    = RUN;
         end
      end

      // The ready and run flags are computed from the next state so they stay registered outputs.
      load_ready_d = (state_d == LOADING) && !prog_len_d[ADDR_W];
      run_ready_d  = (state_d == RUN);

      fetch_acc     = fetch_en && (state_q == RUN);
      fetch_hit     = fetch_acc && ({1'b0, fetch_addr} < prog_len_q);
      fetch_valid_d = fetch_acc;
      sel_ram_d     = fetch_en ? fetch_hit : sel_ram_q;
   end

   // NOTE: sequential state updates with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= EMPTY;
         prog_len_q    <= '0;
         overflow_q    <= 1'b0;
         load_ready_q  <= 1'b0;
         run_ready_q   <= 1'b0;
         fetch_valid_q <= 1'b0;
         sel_ram_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         prog_len_q    <= prog_len_d;
         overflow_q    <= overflow_d;
         load_ready_q  <= load_ready_d;
         run_ready_q   <= run_ready_d;
         fetch_valid_q <= fetch_valid_d;
         sel_ram_q     <= sel_ram_d;
      end
   end

   prog_mem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (prog_len_q[ADDR_W-1:0]),
      .wdata (load_data),
      .re    (fetch_hit),
      .raddr (fetch_addr),
      .rdata (ram_rdata)
   );

   // The RAM read register only updates on a hit, so both sources hold when fetch_en is low.
   assign fetch_data    = sel_ram_q ? ram_rdata : DATA_W'(NOP);
   assign fetch_valid   = fetch_valid_q;
   assign load_ready    = load_ready_q;
   assign run_ready     = run_ready_q;
   assign load_overflow = overflow_q;
   assign prog_len      = prog_len_q;

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised, loadable program memory; successor to the fixed combinational instruction ROM. Holds the CPU instruction stream in a synchronous RAM. A byte-stream load port with a valid/ready handshake fills the RAM at runtime, so programs no longer have to be hard-coded. The CPU fetch port gets a registered read with 1-cycle latency. Unloaded addresses read as zero (NOP), preserving old ROM default behaviour.

## Interface
- `ADDR_W`, default 8: fetch/load address width; depth = 2**ADDR_W words.
- `DATA_W`, default 8: instruction word width.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  fetch request this cycle.
- `fetch_addr`  in  ADDR_W  fetch address.
- `fetch_data`  out  DATA_W  registered fetch result.
- `fetch_valid`  out  1  `fetch_data` is valid (1 cycle after an accepted fetch).
- `load_start`  in  1  begin a new load; clears program length.
- `load_valid`  in  1  `load_data` is presented.
- `load_last`  in  1  qualifies the final word of the load.
- `load_data`  in  DATA_W  word to write.
- `load_ready`  out  1  block accepts a word this cycle.
- `run_ready`  out  1  program loaded; fetch port active.
- `load_overflow`  out  1  sticky: the load exceeded depth.
- `prog_len`  out  ADDR_W+1  number of words loaded, 0..2**ADDR_W.

## Operation
- States: `EMPTY`, `LOADING`, `RUN`.
- `reset` sets the state to `EMPTY`.
  - `fetch_data`=0, `fetch_valid`=0, `load_ready`=0, `run_ready`=0, `load_overflow`=0, `prog_len`=0.
  - RAM contents are not cleared; the length gate below makes them invisible.
- `load_start` is honoured in any state. It moves to `LOADING` and clears `prog_len` and `load_overflow`.
  - In `LOADING`, `load_start` restarts the load from address 0.
  - `load_start` takes priority over a same-cycle `load_valid`; that word is dropped.
- `LOADING`:
  - `load_ready`=1 while `prog_len` < 2**ADDR_W.
  - Transfer = `load_valid` & `load_ready`. It writes `load_data` at address `prog_len`[ADDR_W-1:0], then `prog_len`++.
  - A transfer with `load_last`=1 moves to `RUN`.
  - If `prog_len` reaches 2**ADDR_W without `load_last`, `load_ready` drops to 0.
    - A further `load_valid` sets `load_overflow`=1 and moves to `RUN`, keeping the full image.
    - The address never wraps.
- `RUN`: `run_ready`=1 and `load_ready`=0.
  - `fetch_en` causes `fetch_data` next cycle = RAM[`fetch_addr`] if `fetch_addr` < `prog_len`, else 0. `fetch_valid`=1 next cycle.
- `EMPTY` / `LOADING`: `fetch_en` is ignored; next cycle `fetch_valid`=0 and `fetch_data`=0.
- Without `fetch_en`, `fetch_valid` is 0 and `fetch_data` holds its last value.

## Timing
- Fetch latency: 1 cycle, address to data; back-to-back fetches give 1 word per cycle.
- Load throughput: 1 word per cycle while `load_ready`=1.
- `load_ready` is a registered function of state and `prog_len`; it does not depend combinationally on `load_valid`.
- `run_ready` rises the cycle after the `load_last` transfer. A fetch issued in that same cycle is valid.
- Reset mid-load: the next cycle is `EMPTY` and `prog_len`=0. Partial data is discarded logically.
- `prog_len` compare is ADDR_W+1 wide, so a full load (`prog_len`=2**ADDR_W) makes every address readable.

## Structure
- `prog_mem_pkg`:
  - state enum `prog_mem_state_t` {`EMPTY`, `LOADING`, `RUN`};
  - default `ADDR_W`/`DATA_W` localparams;
  - `NOP` word constant (all zeros).
- Sub-module `prog_mem_ram`: one write port and one registered read port, parametrised by `ADDR_W`/`DATA_W`, infers block RAM, no reset on the array.
- The top holds the FSM, `prog_len` counter, overflow flag and fetch gating.

## Test plan
- Reset, then `fetch_en` at addr 0x00 → `fetch_valid`=0, `fetch_data`=0x00, `run_ready`=0.
- Load 18 words 0x01, 0x82, …, 0xC4 (last flagged) → `prog_len`=18, `run_ready`=1; fetch 0x00..0x11 returns them with 1-cycle latency; fetch 0x12 → 0x00.
- Load with `load_valid` toggling every other cycle → all words written in order, with no drops or duplicates.
- `ADDR_W`=4: push 17 words, none marked last → after 16, `load_ready`=0; 17th `load_valid` sets `load_overflow`=1, state `RUN`, `prog_len`=16; fetch 0xF returns word 16.
- `load_start` asserted mid-load after 5 words, then 3 words loaded → `prog_len`=3; fetch addr 4 → 0x00.
- `reset` asserted during `RUN` → next cycle `run_ready`=0, `prog_len`=0; fetches return 0 until a new load completes.
